// File: rtl/chip_spi_configurator.sv
// chip_spi_configurator: power-up SPI sequencer (CDCE62002 regs, PLL lock, AFE7225 table) plus user CDCE frames.
// Optional macro LOCK_TIMEOUT_EN: leave WAIT_LOCK after LOCK_TIMEOUT cycles even without lock.
module chip_spi_configurator #(
  parameter int SCLK_HALF = 4,
  parameter logic [31:0] CDCE_REG0 = 32'h8184_0320,
  parameter logic [31:0] CDCE_REG1 = 32'h8340_0141,
  parameter int AFE_WORDS = 43,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_tranciver_busy,
  input  logic [31:0] i_tranciver_din,
  input  logic        i_tranciver_din_rdy,
  output logic        o_afe7225_spi_clk,
  output logic        o_afe7225_spi_mosi,
  input  logic        i_afe7225_spi_miso,
  output logic        o_afe7225_spi_le,
  output logic        o_afe7225_pd,
  output logic        o_cdce62002_spi_clk,
  output logic        o_cdce62002_spi_mosi,
  input  logic        i_cdce62002_spi_miso,
  output logic        o_cdce62002_spi_le,
  output logic        o_cdce62002_pd_n,
  input  logic        i_cdce62002_pll_lock,
  output logic        o_clk_sel
);
  typedef enum logic [2:0] {CDCE_CFG, WAIT_LOCK, AFE_CFG, IDLE, USER} state_t;
  typedef enum logic [1:0] {P_GAP, P_LOW, P_HIGH, P_TAIL} phase_t;
  localparam int CW = $clog2(2 * SCLK_HALF);
  localparam logic [CW-1:0] HALF = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] GAP = CW'(2 * SCLK_HALF - 1);
  state_t state;
  phase_t ph;
  logic [CW-1:0] cnt;
  logic [31:0] sr, ns, word, user;
  logic [5:0] bits;
  logic [7:0] idx;
  logic [1:0] lock_sync, sclk, mosi, le;
  logic bus, nbus, want, tail, last, lock_ok, unused;
  assign unused = i_afe7225_spi_miso ^ i_cdce62002_spi_miso;
`ifdef LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign lock_ok = lock_sync[1] || tcnt == TW'(LOCK_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else tcnt <= (state == WAIT_LOCK) ? tcnt + 1'b1 : '0;
  end
`else
  assign lock_ok = lock_sync[1];
`endif
  // Bus 1 is the AFE (16-bit MSB first), bus 0 the CDCE (32-bit LSB first)
  assign nbus = state == AFE_CFG || state == WAIT_LOCK;
  assign want = state == CDCE_CFG || state == USER || state == AFE_CFG || (state == WAIT_LOCK && lock_ok);
  assign word = nbus ? {idx, (idx == 8'd0) ? 8'h80 : 8'h00, 16'h0000} :
                (state == USER) ? user : idx[0] ? CDCE_REG1 : CDCE_REG0;
  assign ns = bus ? {sr[30:0], 1'b0} : {1'b0, sr[31:1]};
  assign tail = ph == P_TAIL && cnt == '0;
  assign last = idx == 8'(AFE_WORDS - 1);
  assign {o_afe7225_spi_clk, o_cdce62002_spi_clk} = sclk;
  assign {o_afe7225_spi_mosi, o_cdce62002_spi_mosi} = mosi;
  assign {o_afe7225_spi_le, o_cdce62002_spi_le} = le;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CDCE_CFG;
      ph <= P_GAP;
      cnt <= GAP;
      sr <= '0;
      user <= '0;
      bits <= '0;
      idx <= '0;
      bus <= 1'b0;
      lock_sync <= '0;
      sclk <= '0;
      mosi <= '0;
      le <= '1;
      o_tranciver_busy <= 1'b1;
      o_afe7225_pd <= 1'b1;
      o_cdce62002_pd_n <= 1'b0;
      o_clk_sel <= 1'b0;
    end else begin
      o_cdce62002_pd_n <= 1'b1;
      o_clk_sel <= 1'b1;
      lock_sync <= {lock_sync[0], i_cdce62002_pll_lock};
      if (cnt != '0) cnt <= cnt - 1'b1;
      else case (ph)
        P_GAP: if (want) begin
          bus <= nbus;
          sr <= word;
          bits <= nbus ? 6'd16 : 6'd32;
          mosi[nbus] <= nbus ? word[31] : word[0];
          le[nbus] <= 1'b0;
          ph <= P_LOW;
          cnt <= HALF;
        end
        P_LOW: begin
          sclk[bus] <= 1'b1;
          ph <= P_HIGH;
          cnt <= HALF;
        end
        P_HIGH: begin
          sclk[bus] <= 1'b0;
          cnt <= HALF;
          if (bits == 6'd1) begin
            mosi[bus] <= 1'b0;
            ph <= P_TAIL;
          end else begin
            sr <= ns;
            mosi[bus] <= bus ? ns[31] : ns[0];
            bits <= bits - 1'b1;
            ph <= P_LOW;
          end
        end
        default: begin
          le[bus] <= 1'b1;
          ph <= P_GAP;
          cnt <= GAP;
        end
      endcase
      case (state)
        CDCE_CFG: if (tail) begin
          idx <= idx[0] ? 8'd0 : 8'd1;
          if (idx[0]) state <= WAIT_LOCK;
        end
        WAIT_LOCK: if (lock_ok) begin
          o_afe7225_pd <= 1'b0;
          state <= AFE_CFG;
        end
        AFE_CFG: if (tail) begin
          idx <= last ? 8'd0 : idx + 1'b1;
          if (last) state <= IDLE;
        end
        USER: if (tail) state <= IDLE;
        default: if (o_tranciver_busy) o_tranciver_busy <= 1'b0;
          else if (i_tranciver_din_rdy) begin
            user <= i_tranciver_din;
            o_tranciver_busy <= 1'b1;
            state <= USER;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_chip_spi_configurator.sv
// tb_chip_spi_configurator: directed/random bench with bus monitors and a frame-list reference model.
module tb_chip_spi_configurator;
  logic clk = 1'b0, rst = 1'b1;
  logic busy, din_rdy, lock;
  logic [31:0] din;
  logic a_clk, a_mosi, a_le, a_pd, c_clk, c_mosi, c_le, c_pd_n, clk_sel;
  int passed = 0, total = 0;
  logic [31:0] cq[$];
  int cnq[$];
  logic [15:0] aq[$];
  int anq[$];
  logic [31:0] c_acc;
  logic [15:0] a_acc;
  int c_n = 0, a_n = 0, c_viol = 0, a_viol = 0;

  always #5 clk = ~clk;

  chip_spi_configurator dut (
    .clk(clk), .rst(rst), .o_tranciver_busy(busy), .i_tranciver_din(din),
    .i_tranciver_din_rdy(din_rdy), .o_afe7225_spi_clk(a_clk), .o_afe7225_spi_mosi(a_mosi),
    .i_afe7225_spi_miso(1'b0), .o_afe7225_spi_le(a_le), .o_afe7225_pd(a_pd),
    .o_cdce62002_spi_clk(c_clk), .o_cdce62002_spi_mosi(c_mosi), .i_cdce62002_spi_miso(1'b0),
    .o_cdce62002_spi_le(c_le), .o_cdce62002_pd_n(c_pd_n), .i_cdce62002_pll_lock(lock),
    .o_clk_sel(clk_sel)
  );

  // Bus monitors: assemble frames bit by bit and flag edges outside a frame or on both buses
  always @(negedge c_le) begin c_acc = '0; c_n = 0; end
  always @(posedge c_clk) begin
    if (c_n < 32) c_acc[c_n] = c_mosi;
    c_n++;
    if (c_le !== 1'b0 || a_le !== 1'b1) c_viol++;
  end
  always @(posedge c_le) begin cq.push_back(c_acc); cnq.push_back(c_n); end
  always @(negedge a_le) begin a_acc = '0; a_n = 0; end
  always @(posedge a_clk) begin
    a_acc = {a_acc[14:0], a_mosi};
    a_n++;
    if (a_le !== 1'b0 || c_le !== 1'b1) a_viol++;
  end
  always @(posedge a_le) begin aq.push_back(a_acc); anq.push_back(a_n); end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy !== 1'b0; i++) @(negedge clk);
    chk("busy_fall", busy, 1'b0);
  endtask

  task automatic pulse_rdy(input logic [31:0] w);
    din = w;
    din_rdy = 1'b1;
    @(negedge clk);
    din_rdy = 1'b0;
    din = ~w;
  endtask

  // Reference: CDCE_REG0, CDCE_REG1, then AFE entries {k, k==0 ? 80 : 00}
  task automatic check_config(input int cb, input int ab);
    logic [15:0] e;
    chk("cdce_frames", cq.size() - cb, 2);
    if (cq.size() - cb >= 2) begin
      chk("cdce_reg0", cq[cb], 32'h8184_0320);
      chk("cdce_reg1", cq[cb + 1], 32'h8340_0141);
      chk("cdce_bits", cnq[cb] + cnq[cb + 1], 64);
    end
    chk("afe_frames", aq.size() - ab, 43);
    for (int k = 0; k < aq.size() - ab; k++) begin
      e = {8'(k), (k == 0) ? 8'h80 : 8'h00};
      chk($sformatf("afe_word_%0d", k), aq[ab + k], e);
      chk($sformatf("afe_bits_%0d", k), anq[ab + k], 16);
    end
  endtask

  initial begin
    int n, cb, ab, nc, na;
    logic [31:0] w;
    din = '0; din_rdy = 1'b0; lock = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_sclk", {a_clk, c_clk}, 2'b00);
    chk("rst_mosi", {a_mosi, c_mosi}, 2'b00);
    chk("rst_le", {a_le, c_le}, 2'b11);
    chk("rst_afe_pd", a_pd, 1'b1);
    chk("rst_pd_n", c_pd_n, 1'b0);
    chk("rst_clk_sel", clk_sel, 1'b0);
    cb = cq.size(); ab = aq.size();
    rst = 1'b0;
    @(negedge clk);
    chk("pd_n_up", c_pd_n, 1'b1);
    chk("clk_sel_up", clk_sel, 1'b1);
    repeat (2) begin
      repeat ($urandom_range(5, 100)) @(negedge clk);
      pulse_rdy($urandom);
    end
    for (int i = 0; i < 3000 && cq.size() - cb < 2; i++) @(negedge clk);
    repeat (300) @(negedge clk);
    chk("nolock_afe_frames", aq.size() - ab, 0);
    chk("nolock_afe_le", a_le, 1'b1);
    chk("nolock_afe_pd", a_pd, 1'b1);
    chk("nolock_busy", busy, 1'b1);
    lock = 1'b1;
    n = 0;
    while (a_le === 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("lock_to_afe", n <= 3, 1'b1);
    chk("afe_pd_low", a_pd, 1'b0);
    repeat ($urandom_range(50, 2000)) @(negedge clk);
    pulse_rdy($urandom);
    wait_idle(20000);
    chk("idle_afe_le", a_le, 1'b1);
    check_config(cb, ab);
    for (int u = 0; u < 5; u++) begin
      w = (u == 0) ? 32'hA5A5_0F0F : $urandom;
      nc = cq.size(); na = aq.size();
      pulse_rdy(w);
      chk("user_busy", busy, 1'b1);
      repeat ($urandom_range(2, 200)) @(negedge clk);
      pulse_rdy($urandom);
      wait_idle(1000);
      chk("user_le_high", c_le, 1'b1);
      chk("user_frames", cq.size() - nc, 1);
      if (cq.size() > nc) begin
        chk("user_word", cq[nc], w);
        chk("user_bits", cnq[nc], 32);
      end
      chk("user_afe_quiet", aq.size() - na, 0);
      repeat (30) @(negedge clk);
      chk("no_queued_busy", busy, 1'b0);
      chk("no_queued_frame", cq.size() - nc, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    cb = cq.size(); ab = aq.size();
    rst = 1'b0;
    n = $urandom_range(1, 5);
    for (int i = 0; i < 5000 && aq.size() - ab < n; i++) @(negedge clk);
    for (int i = 0; i < 100 && a_le !== 1'b0; i++) @(negedge clk);
    chk("mid_afe_frame", a_le, 1'b0);
    repeat ($urandom_range(5, 60)) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_le", a_le, 1'b1);
    chk("abort_sclk", a_clk, 1'b0);
    chk("abort_mosi", a_mosi, 1'b0);
    chk("abort_busy", busy, 1'b1);
    chk("abort_afe_pd", a_pd, 1'b1);
    @(negedge clk);
    cb = cq.size(); ab = aq.size();
    rst = 1'b0;
    wait_idle(20000);
    check_config(cb, ab);
    chk("cdce_protocol", c_viol, 0);
    chk("afe_protocol", a_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/chip_spi_configurator.md
Name: chip_spi_configurator

Overview:
- Power-up configuration sequencer for the CDCE62002 clock synthesizer and the AFE7225 analog front end.
- After reset it runs the sequence below, then sits idle:
  1. Writes the CDCE62002 register set over its SPI bus.
  2. Waits for PLL lock.
  3. Writes the AFE7225 register table over a second SPI bus.
- When idle, it accepts single 32-bit user frames and sends them to the CDCE62002.
- Sits between board-level clock/AFE pins and system control logic.

Parameters:
- SCLK_HALF, 4, clk cycles per SPI clock half-period (default gives 12.5 MHz at 100 MHz clk); minimum 2.
- CDCE_REG0, 32'h8184_0320, CDCE62002 register-0 frame.
- CDCE_REG1, 32'h8340_0141, CDCE62002 register-1 frame.
- AFE_WORDS, 43, number of AFE7225 table entries (1..255).
- LOCK_TIMEOUT, 1_000_000, clk cycles to wait for lock (used only with the optional feature).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- o_tranciver_busy  out  1  high while a configuration or user frame is in progress.
- i_tranciver_din  in  32  user frame for the CDCE62002.
- i_tranciver_din_rdy  in  1  one-cycle strobe; accepted only when busy=0.
- o_afe7225_spi_clk  out  1  AFE SPI clock.
- o_afe7225_spi_mosi  out  1  AFE SPI data.
- i_afe7225_spi_miso  in  1  unused (no readback).
- o_afe7225_spi_le  out  1  AFE chip enable, active low.
- o_afe7225_pd  out  1  AFE power-down, active high.
- o_cdce62002_spi_clk  out  1  CDCE SPI clock.
- o_cdce62002_spi_mosi  out  1  CDCE SPI data.
- i_cdce62002_spi_miso  in  1  unused.
- o_cdce62002_spi_le  out  1  CDCE latch enable, active low.
- o_cdce62002_pd_n  out  1  CDCE power-down, active low.
- i_cdce62002_pll_lock  in  1  asynchronous lock indicator.
- o_clk_sel  out  1  board clock select.

Behaviour:
- Reset values:
  - busy=1.
  - Both spi_clk=0, both mosi=0, both le=1.
  - afe7225_pd=1, cdce62002_pd_n=0, clk_sel=0.
- First clk after reset release: pd_n=1, clk_sel=1. Both are static afterwards.
- FSM states: CDCE_CFG, WAIT_LOCK, AFE_CFG, IDLE, USER.
  - CDCE_CFG sends CDCE_REG0 then CDCE_REG1.
  - WAIT_LOCK waits for the synchronized lock signal to be 1.
  - On lock, afe7225_pd drops to 0 and the FSM enters AFE_CFG.
  - AFE_CFG sends entries 0..AFE_WORDS-1, then enters IDLE with busy=0.
- AFE entry k is 16 bits: {k[7:0], data}. Data is 8'h80 for k=0 (soft reset) and 8'h00 otherwise.
- Lock input: 2-flop synchronizer. Lock is level-checked only in WAIT_LOCK; later loss of lock is ignored.
- Frame format, both buses:
  - Idle bus: le=1, sclk=0.
  - Frame start: le falls; after SCLK_HALF cycles the first rising sclk occurs.
  - mosi changes only while sclk=0 and is stable across each rising edge.
  - After the last bit, sclk returns to 0, then le rises after SCLK_HALF cycles.
  - le stays high at least 2*SCLK_HALF cycles before the next frame.
- CDCE frames: 32 bits, LSB first. AFE frames: 16 bits, MSB first.
- Only one bus is active at a time; the other holds idle levels.
- USER handshake:
  - In IDLE, din_rdy=1 latches din and sets busy=1 on the next clk edge.
  - The FSM enters USER, sends the 32-bit frame on the CDCE bus, returns to IDLE, and busy=0 one cycle after le rises.
  - din_rdy while busy=1 is ignored, including during power-up configuration. It is not queued.
- Asynchronous rst at any time aborts the frame, forces reset values, and restarts the full sequence.

Optional Feature:
- Macro LOCK_TIMEOUT_EN.
- Defined: WAIT_LOCK counts clk cycles. If lock has not been seen after LOCK_TIMEOUT cycles, the FSM proceeds to AFE_CFG exactly as if lock had occurred.
- Undefined: WAIT_LOCK waits indefinitely. The counter is not built.

Test Plan:
- Reset released, lock tied 1 → CDCE bus carries 32'h81840320 then 32'h83400141, LSB first, 64 rising sclk total. Then AFE bus carries 43 frames: frame 0 = 16'h0080, frame 42 = 16'h2A00. busy falls after the last AFE le rise.
- Lock held 0 → no AFE activity, afe7225_pd stays 1, busy stays 1. Raise lock → AFE sequence starts within 3 clk; afe7225_pd=0.
- IDLE, din=32'hA5A5_0F0F, one-cycle rdy → busy=1 next cycle. CDCE bus shifts bits 0..31 of the word. busy=0 after le rises; AFE bus idle.
- din_rdy pulsed during power-up config and during a USER frame → ignored; no extra frames.
- rst asserted mid-AFE frame → immediate le=1, sclk=0, busy=1, afe7225_pd=1. After release the sequence restarts with CDCE_REG0.
- With LOCK_TIMEOUT_EN and LOCK_TIMEOUT=100, lock=0 → AFE_CFG starts 100 cycles after WAIT_LOCK entry.
